// File: rtl/det_feed_ctrl_if.sv
// Host-side word handshake for det_feed_ctrl.
//   in_valid  host -> ctrl  word valid
//   in_ready  ctrl -> host  controller can accept a word
//   in_data   host -> ctrl  word to serialize, MSB first
//   in_chain  host -> ctrl  1 = keep detector state from previous word
interface det_feed_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_chain;

  modport master (
    output in_valid,
    output in_data,
    output in_chain,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_chain,
    output in_ready
  );

endinterface

// File: rtl/det_feed_ctrl.sv
// Sequencer for a 1-bit serial sequence detector. Accepts a parallel word
// from the host, optionally clears the detector, shifts the word out MSB
// first with a per-bit enable strobe, counts cycles where the detector
// reports a match, then pulses done with the (saturating) match count.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   host         word handshake (slave side): in_valid/in_ready/in_data/in_chain
//   det_rst_o    detector reset, combinational: rst or clear cycle
//   det_din_o    serial bit to detector
//   det_en_o     bit strobe; detector advances on edges with det_en_o=1
//   det_out_i    detector output, valid the cycle after a strobe
//   match_cnt_o  matches counted in last word, held until next accept
//   sat_o        match count saturated during last word
//   done_o       one-cycle pulse, result valid
module det_feed_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  det_feed_ctrl_if.slave    host,
  output logic              det_rst_o,
  output logic              det_din_o,
  output logic              det_en_o,
  input  logic              det_out_i,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              sat_o,
  output logic              done_o
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic                en_d_q;
  logic                det_en_q, det_en_d;
  logic                det_din_q, det_din_d;
  logic                done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      en_d_q    <= 1'b0;
      det_en_q  <= 1'b0;
      det_din_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      en_d_q    <= det_en_q;
      det_en_q  <= det_en_d;
      det_din_q <= det_din_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath and registered-output lookahead
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    det_en_d  = 1'b0;
    det_din_d = 1'b0;
    done_d    = 1'b0;

    // The detector result for a strobed bit appears one cycle later; this
    // window runs through DRAIN so the final bit is still counted.
    if (en_d_q && det_out_i) begin
      if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (host.in_valid) begin
          shreg_d  = host.in_data;
          bitcnt_d = BIT_W'(DATA_W - 1);
          cnt_d    = '0;
          sat_d    = 1'b0;
          state_d  = host.in_chain ? ST_SHIFT : ST_CLR;
        end
      end
      ST_CLR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        if (bitcnt_q == '0) begin
          state_d = ST_DRAIN;
        end else begin
          bitcnt_d = bitcnt_q - BIT_W'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobe and data are registered, so derive them from the next state:
    // the bit presented is always the MSB of the shift register it will hold.
    det_en_d  = (state_d == ST_SHIFT);
    det_din_d = det_en_d & shreg_d[DATA_W-1];
    done_d    = (state_d == ST_DONE);
  end

  assign host.in_ready = (state_q == ST_IDLE);
  // Must follow rst in the same cycle, hence combinational.
  assign det_rst_o     = rst | (state_q == ST_CLR);
  assign det_en_o      = det_en_q;
  assign det_din_o     = det_din_q;
  assign match_cnt_o   = cnt_q;
  assign sat_o         = sat_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_det_feed_ctrl.sv
// Self-checking bench for det_feed_ctrl: an 8-bit/8-bit instance and a
// 16-bit/2-bit instance, each driving a Moore "101" detector model.
module tb_det_feed_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  bit   use_b;
  int   checks = 0;
  int   errors = 0;

  det_feed_ctrl_if #(.DATA_W(8))  ifa ();
  det_feed_ctrl_if #(.DATA_W(16)) ifb ();

  logic       a_det_rst, a_det_din, a_det_en, a_det_out, a_sat, a_done;
  logic [7:0] a_cnt;
  logic       b_det_rst, b_det_din, b_det_en, b_det_out, b_sat, b_done;
  logic [1:0] b_cnt;

  det_feed_ctrl #(.DATA_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .host(ifa),
    .det_rst_o(a_det_rst), .det_din_o(a_det_din), .det_en_o(a_det_en),
    .det_out_i(a_det_out), .match_cnt_o(a_cnt), .sat_o(a_sat), .done_o(a_done)
  );

  det_feed_ctrl #(.DATA_W(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .host(ifb),
    .det_rst_o(b_det_rst), .det_din_o(b_det_din), .det_en_o(b_det_en),
    .det_out_i(b_det_out), .match_cnt_o(b_cnt), .sat_o(b_sat), .done_o(b_done)
  );

  // Moore overlapping "101" detector: 0=S0 1=S1 2=S10 3=S101
  function automatic int det_next(input int s, input logic d);
    case (s)
      0:       return d ? 1 : 0;
      1:       return d ? 1 : 2;
      2:       return d ? 3 : 0;
      default: return d ? 1 : 2;
    endcase
  endfunction

  int da = 0;
  int db = 0;
  always @(posedge clk) begin
    if (a_det_rst) da <= 0;
    else if (a_det_en) da <= det_next(da, a_det_din);
    if (b_det_rst) db <= 0;
    else if (b_det_en) db <= det_next(db, b_det_din);
  end
  assign a_det_out = (da == 3);
  assign b_det_out = (db == 3);

  // Observation mux for the instance under test
  logic o_rst, o_din, o_en, o_ready, o_done, o_sat;
  int   o_cnt;
  always_comb begin
    o_rst   = use_b ? b_det_rst : a_det_rst;
    o_din   = use_b ? b_det_din : a_det_din;
    o_en    = use_b ? b_det_en : a_det_en;
    o_ready = use_b ? ifb.in_ready : ifa.in_ready;
    o_done  = use_b ? b_done : a_done;
    o_sat   = use_b ? b_sat : a_sat;
    o_cnt   = use_b ? int'(b_cnt) : int'(a_cnt);
  end

  // Reference: match = last three stream bits since clear equal 1,0,1
  int ref_win [2];
  int ref_n   [2];

  task automatic ref_clear();
    for (int u = 0; u < 2; u++) begin
      ref_win[u] = 0;
      ref_n[u]   = 0;
    end
  endtask

  task automatic ref_word(input int u, input logic [15:0] d, input int w,
                          input bit chain, output int raw);
    raw = 0;
    if (!chain) begin
      ref_win[u] = 0;
      ref_n[u]   = 0;
    end
    for (int i = w - 1; i >= 0; i--) begin
      ref_win[u] = ((ref_win[u] * 2) + int'(d[i])) % 8;
      ref_n[u]   = ref_n[u] + 1;
      if (ref_n[u] >= 3 && ref_win[u] == 5) raw++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [15:0] d, input bit c);
    if (use_b) begin
      ifb.in_valid = v; ifb.in_data = d; ifb.in_chain = c;
    end else begin
      ifa.in_valid = v; ifa.in_data = d[7:0]; ifa.in_chain = c;
    end
  endtask

  // Pushes one word and records what the controller does until it is idle again
  task automatic run_word(input logic [15:0] d, input bit chain,
                          output int done_k, output int ndone, output int nrst,
                          output int rst_k, output int en_first, output int nen,
                          output logic [15:0] bits, output int ready_k,
                          output int cnt_done, output bit sat_done,
                          output int cnt_final);
    int w;
    w = use_b ? 16 : 8;
    done_k = -1; ndone = 0; nrst = 0; rst_k = -1; en_first = -1; nen = 0;
    bits = '0; ready_k = -1; cnt_done = -1; sat_done = 1'b0;
    set_in(1'b1, d, chain);
    step();
    set_in(1'b0, 16'($urandom), 1'($urandom));
    for (int k = 1; k <= w + 6; k++) begin
      if (o_done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k; cnt_done = o_cnt; sat_done = o_sat;
        end
      end
      if (o_rst) begin
        nrst++;
        if (rst_k < 0) rst_k = k;
      end
      if (o_en) begin
        nen++;
        bits = {bits[14:0], o_din};
        if (en_first < 0) en_first = k;
      end
      if (o_ready && ready_k < 0) ready_k = k;
      step();
    end
    cnt_final = o_cnt;
  endtask

  task automatic test_reset();
    use_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_chain = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_chain = 1'b0;
    rst = 1'b1;
    step(); step();
    ref_clear();
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", ifa.in_ready); end
    checks++; if (a_det_rst !== 1'b1) begin errors++; $display("FAIL reset det_rst: got %b expected 1", a_det_rst); end
    checks++; if (a_det_en !== 1'b0 || a_det_din !== 1'b0) begin errors++; $display("FAIL reset en/din: got %b/%b expected 0/0", a_det_en, a_det_din); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", a_done); end
    checks++; if (a_cnt !== 8'd0 || a_sat !== 1'b0) begin errors++; $display("FAIL reset cnt/sat: got %0d/%b expected 0/0", a_cnt, a_sat); end
    checks++; if (b_cnt !== 2'd0 || b_sat !== 1'b0) begin errors++; $display("FAIL reset b cnt/sat: got %0d/%b expected 0/0", b_cnt, b_sat); end
    // rst wins over in_valid
    ifa.in_valid = 1'b1; ifa.in_data = 8'hA5;
    step();
    ifa.in_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (ifa.in_ready !== 1'b1 || a_det_en !== 1'b0) begin errors++; $display("FAIL reset rst_wins: got ready=%b en=%b expected 1/0", ifa.in_ready, a_det_en); end
    checks++; if (a_det_rst !== 1'b0) begin errors++; $display("FAIL reset det_rst_release: got %b expected 0", a_det_rst); end
  endtask

  task automatic test_idle();
    int bad = 0;
    use_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.in_ready !== 1'b1 || a_det_en !== 1'b0 || a_done !== 1'b0 || a_cnt !== 8'd0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_directed();
    logic [15:0] td [3];
    bit          tc [3];
    int done_k, ndone, nrst, rst_k, en_first, nen, ready_k, cnt_done, cnt_final;
    int raw, exp_done, exp_cnt;
    bit sat_done;
    logic [15:0] bits;
    td[0] = 16'h00A5; tc[0] = 1'b0;
    td[1] = 16'h0040; tc[1] = 1'b1;
    td[2] = 16'h0040; tc[2] = 1'b0;
    use_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ref_word(0, td[i], 8, tc[i], raw);
      exp_cnt  = (raw > 255) ? 255 : raw;
      exp_done = tc[i] ? 10 : 11;
      run_word(td[i], tc[i], done_k, ndone, nrst, rst_k, en_first, nen, bits,
               ready_k, cnt_done, sat_done, cnt_final);
      checks++; if (done_k != exp_done) begin errors++; $display("FAIL directed[%0d] done_cycle: got %0d expected %0d", i, done_k, exp_done); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL directed[%0d] done_pulses: got %0d expected 1", i, ndone); end
      checks++; if (nrst != (tc[i] ? 0 : 1)) begin errors++; $display("FAIL directed[%0d] det_rst_cycles: got %0d expected %0d", i, nrst, tc[i] ? 0 : 1); end
      if (!tc[i]) begin
        checks++; if (rst_k != 1) begin errors++; $display("FAIL directed[%0d] det_rst_cycle: got %0d expected 1", i, rst_k); end
      end
      checks++; if (en_first != (tc[i] ? 1 : 2) || nen != 8) begin errors++; $display("FAIL directed[%0d] strobe: got first=%0d n=%0d expected %0d/8", i, en_first, nen, tc[i] ? 1 : 2); end
      checks++; if (bits !== td[i]) begin errors++; $display("FAIL directed[%0d] serial_bits: got %h expected %h", i, bits, td[i]); end
      checks++; if (ready_k != exp_done + 1) begin errors++; $display("FAIL directed[%0d] ready_return: got %0d expected %0d", i, ready_k, exp_done + 1); end
      checks++; if (cnt_done != exp_cnt || sat_done != (raw > 255)) begin errors++; $display("FAIL directed[%0d] count: got %0d sat=%b expected %0d sat=%b", i, cnt_done, sat_done, exp_cnt, raw > 255); end
      checks++; if (cnt_final != exp_cnt) begin errors++; $display("FAIL directed[%0d] count_held: got %0d expected %0d", i, cnt_final, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int raw1, raw2, nd, d1, d2, c1, c2, first_ready, ready_early, ready_mid;
    use_b = 1'b0;
    ref_word(0, 16'h55, 8, 1'b0, raw1);
    ref_word(0, 16'hFF, 8, 1'b0, raw2);
    nd = 0; d1 = -1; d2 = -1; c1 = -1; c2 = -1;
    first_ready = -1; ready_early = 0; ready_mid = 0;
    set_in(1'b1, 16'h55, 1'b0);
    step();
    ifa.in_data = 8'hFF;
    for (int k = 1; k <= 30; k++) begin
      if (a_done) begin
        nd++;
        if (nd == 1) begin d1 = k; c1 = int'(a_cnt); end
        else if (nd == 2) begin d2 = k; c2 = int'(a_cnt); end
      end
      if (ifa.in_ready) begin
        if (k <= 11) ready_early++;
        if (first_ready < 0) first_ready = k;
        else if (k > first_ready && k <= 23) ready_mid++;
      end
      if (first_ready > 0 && k > first_ready) ifa.in_valid = 1'b0;
      step();
    end
    ifa.in_valid = 1'b0;
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b done_pulses: got %0d expected 2", nd); end
    checks++; if (d1 != 11 || d2 != 23) begin errors++; $display("FAIL b2b done_cycles: got %0d,%0d expected 11,23", d1, d2); end
    checks++; if (first_ready != 12 || ready_early != 0 || ready_mid != 0) begin errors++; $display("FAIL b2b in_ready: got first=%0d early=%0d mid=%0d expected 12/0/0", first_ready, ready_early, ready_mid); end
    checks++; if (c1 != raw1 || c2 != raw2) begin errors++; $display("FAIL b2b counts: got %0d,%0d expected %0d,%0d", c1, c2, raw1, raw2); end
  endtask

  task automatic test_reset_mid_word();
    int nd, done_k, ndone, nrst, rst_k, en_first, nen, ready_k, cnt_done, cnt_final, raw;
    bit sat_done;
    logic [15:0] bits;
    use_b = 1'b0;
    set_in(1'b1, 16'hA5, 1'b0);
    step();
    set_in(1'b0, 16'h0, 1'b0);
    for (int k = 1; k < 6; k++) step();
    rst = 1'b1;
    #1;
    checks++; if (a_det_rst !== 1'b1) begin errors++; $display("FAIL midrst det_rst: got %b expected 1", a_det_rst); end
    step();
    rst = 1'b0;
    ref_clear();
    checks++; if (ifa.in_ready !== 1'b1 || a_cnt !== 8'd0 || a_det_en !== 1'b0 || a_sat !== 1'b0) begin errors++; $display("FAIL midrst state: got ready=%b cnt=%0d en=%b sat=%b expected 1/0/0/0", ifa.in_ready, a_cnt, a_det_en, a_sat); end
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      if (a_done) nd++;
      step();
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL midrst no_done: got %0d pulses expected 0", nd); end
    ref_word(0, 16'h55, 8, 1'b0, raw);
    run_word(16'h55, 1'b0, done_k, ndone, nrst, rst_k, en_first, nen, bits,
             ready_k, cnt_done, sat_done, cnt_final);
    checks++; if (cnt_done != raw || done_k != 11) begin errors++; $display("FAIL midrst next_word: got cnt=%0d done=%0d expected %0d/11", cnt_done, done_k, raw); end
  endtask

  task automatic test_random();
    int done_k, ndone, nrst, rst_k, en_first, nen, ready_k, cnt_done, cnt_final, raw, gap;
    bit sat_done, c;
    logic [15:0] d, bits;
    use_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      d   = 16'($urandom_range(0, 255));
      c   = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      ref_word(0, d, 8, c, raw);
      run_word(d, c, done_k, ndone, nrst, rst_k, en_first, nen, bits,
               ready_k, cnt_done, sat_done, cnt_final);
      checks++; if (done_k != (c ? 10 : 11) || ndone != 1) begin errors++; $display("FAIL random[%0d] done: got cycle=%0d n=%0d expected %0d/1", i, done_k, ndone, c ? 10 : 11); end
      checks++; if (bits !== d) begin errors++; $display("FAIL random[%0d] serial_bits: got %h expected %h", i, bits, d); end
      checks++; if (cnt_done != raw || sat_done != 1'b0) begin errors++; $display("FAIL random[%0d] count: got %0d sat=%b expected %0d sat=0 (data %h chain %b)", i, cnt_done, sat_done, raw, d, c); end
    end
  endtask

  task automatic test_saturation();
    int done_k, ndone, nrst, rst_k, en_first, nen, ready_k, cnt_done, cnt_final, raw, exp_cnt;
    bit sat_done, c;
    logic [15:0] d, bits;
    use_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin d = 16'hAAAA; c = 1'b0; end
      else begin d = 16'($urandom); c = 1'($urandom_range(0, 1)); end
      ref_word(1, d, 16, c, raw);
      exp_cnt = (raw > 3) ? 3 : raw;
      run_word(d, c, done_k, ndone, nrst, rst_k, en_first, nen, bits,
               ready_k, cnt_done, sat_done, cnt_final);
      checks++; if (done_k != (c ? 18 : 19) || ndone != 1) begin errors++; $display("FAIL sat[%0d] done: got cycle=%0d n=%0d expected %0d/1", i, done_k, ndone, c ? 18 : 19); end
      checks++; if (bits !== d || nen != 16) begin errors++; $display("FAIL sat[%0d] serial_bits: got %h n=%0d expected %h/16", i, bits, nen, d); end
      checks++; if (cnt_done != exp_cnt || sat_done != (raw > 3)) begin errors++; $display("FAIL sat[%0d] count: got %0d sat=%b expected %0d sat=%b (raw %0d)", i, cnt_done, sat_done, exp_cnt, raw > 3, raw); end
      checks++; if (cnt_final != exp_cnt) begin errors++; $display("FAIL sat[%0d] count_held: got %0d expected %0d", i, cnt_final, exp_cnt); end
    end
    use_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_directed();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/det_feed_ctrl.md
Name: det_feed_ctrl

Overview:
- Sequencer for the team's 1-bit serial sequence detector (clk/rst/din/out datapath).
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto the detector's din.
- Samples the detector's out after every bit, counts matches per word, then reports the count with a one-cycle done pulse.
- Replaces hand-written for-loop stimulus; lets a host push patterns and read results.

Parameters:
DATA_W, 8, word width / bits shifted per word (>=2)
CNT_W, 8, match counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  host word valid
in_ready  out  1  controller can accept word (IDLE only)
in_data  in  DATA_W  word to serialize, MSB first
in_chain  in  1  captured with word; 1 = keep detector state from previous word, 0 = clear detector first
det_rst  out  1  reset to detector
det_din  out  1  serial bit to detector
det_en  out  1  bit strobe; detector advances on edges where det_en=1
det_out  in  1  detector output, valid the cycle after a det_en cycle
match_cnt  out  CNT_W  matches counted in last word; held until next accept
sat  out  1  match_cnt saturated during last word
done  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (rst=1 at edge): state=IDLE; in_ready=1 after reset; det_din=0, det_en=0, done=0, match_cnt=0, sat=0, shift reg/bit counter=0.
- det_rst = rst OR (state==CLR), combinational.
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. Accept on edge with in_valid&in_ready.
  - At accept: load shift reg=in_data, bitcnt=DATA_W-1, match_cnt=0, sat=0.
  - Next state: CLR if in_chain=0, else SHIFT. in_data is ignored while not IDLE.
- CLR: exactly 1 cycle, det_rst=1, det_en=0 -> SHIFT.
- SHIFT: DATA_W consecutive cycles, det_en=1, det_din=shreg[MSB].
  - Each edge: shift left 1; bitcnt decrements.
  - After bitcnt reaches 0 -> DRAIN.
- Sampling: en_d = det_en delayed 1 cycle. On each edge with en_d=1 and det_out=1, match_cnt increments.
  - Saturates at 2^CNT_W-1; an increment attempted at max sets sat=1.
  - en_d is also active in DRAIN, which captures the last bit's result.
- DRAIN: 1 cycle, det_en=0 -> DONE.
- DONE: done=1 for 1 cycle, in_ready=0 -> IDLE.
- Latency from accept edge T: done high in cycle T+DATA_W+3 (chain=0) or T+DATA_W+2 (chain=1).
- Back-to-back: with in_valid held high, the next accept occurs on the first IDLE cycle after DONE. There is no acceptance during DONE.
- match_cnt and sat are stable from done until the next accept.
- Reset mid-word: abort immediately to IDLE. No done pulse. Counters cleared. det_rst high while rst=1.
- rst and in_valid together: rst wins, word not accepted.

Test Plan:
(Bench model: Moore detector for overlapping "101", registered out, advances only when det_en=1, cleared by det_rst.)
- Reset, then in_data=0xA5, chain=0 -> det_rst high 1 cycle after accept; det_din 1,0,1,0,0,1,0,1; done at T+11; match_cnt=2, sat=0.
- Immediately follow with 0x40, chain=1 -> no det_rst; done at T+10; match_cnt=1. Repeat 0x40 with chain=0 -> match_cnt=0.
- 0x55 chain=0 then 0xFF chain=0, in_valid held continuously -> counts 3 then 0; in_ready low from accept through DONE; second accept on first IDLE cycle; exactly two done pulses.
- DATA_W=16, CNT_W=2, 0xAAAA chain=0 -> raw matches 7; match_cnt=3, sat=1.
- Assert rst for 1 cycle during SHIFT bit 4 of 0xA5 -> no done; next cycle in_ready=1, match_cnt=0, det_en=0. New 0x55 then yields 3.
- in_valid=0 for 20 cycles after reset -> in_ready=1, det_en=0, done=0 throughout; match_cnt stays 0.
